ask_fsk_rx: RTL and testbench
=============================

ASK_FSK_RX -- requirements
Module: ask_fsk_rx

Interface
REQ-001 Parameter WIN_LEN, default 32: PWM frame length in clk cycles, and the length of one measurement window.
REQ-002 Parameter LO_MAX, default 3: a window high-count at or below this value decodes as low duty.
REQ-003 Parameter HI_MIN, default 28: a window high-count at or above this value decodes as high duty.
REQ-004 clk  input  1  sampling clock, same frequency as the transmitter's int_clk; all flops on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_red  input  1  red PWM line, asynchronous to clk.
REQ-007 in_green  input  1  green PWM line, asynchronous to clk.
REQ-008 pair  output  2  last decoded symbol: pair[0] is bits[0], pair[1] is bits[1].
REQ-009 pair_valid  output  1  one-cycle pulse when pair is updated.
REQ-010 carrier_ok  output  1  high while the FSM is in LOCKED.
REQ-011 amb_err  output  1  one-cycle pulse when a window is ambiguous.

Function
REQ-012 Each of in_red and in_green shall pass through a 2-flop synchroniser; all counting uses the synchronised values.
REQ-013 A free-running window counter shall run 0..WIN_LEN-1 and wrap to 0.
REQ-014 Per line, a counter of width clog2(WIN_LEN+1) shall count synchronised-high cycles within the window.
- It is cleared at wrap; the wrap-cycle sample seeds the new count.
REQ-015 At the window's last cycle each line shall be classified from its high-count:
- LOW if count <= LO_MAX.
- HIGH if count >= HI_MIN.
- AMBIG otherwise.
- NONE if count == 0; NONE is a subset of LOW.
REQ-016 Decode: pair[0] = (red == HIGH); pair[1] = pair[0] if green == HIGH, else !pair[0].
REQ-017 FSM states NO_CARRIER, ACQUIRE, LOCKED; evaluated once per window end.
REQ-018 NO_CARRIER -> ACQUIRE when neither line is NONE.
REQ-019 ACQUIRE -> LOCKED after 2 consecutive windows in which neither line is NONE.
REQ-020 ACQUIRE or LOCKED -> NO_CARRIER on any window in which either line is NONE.
REQ-021 In LOCKED, a non-ambiguous window shall update pair and pulse pair_valid in the cycle after the window's last cycle.
- Latency from a line edge to pair_valid is at most WIN_LEN+3 clk cycles.
REQ-022 Outside LOCKED, pair shall hold its value and pair_valid shall stay 0.
REQ-023 Window-end decision and FSM transition occur in the same cycle; a NONE window that ends LOCKED emits no pair_valid.

Reset
REQ-024 While rst_n = 0:
- Synchronisers, counters, pair = 2'b00, pair_valid = 0, amb_err = 0, carrier_ok = 0.
- FSM = NO_CARRIER, window counter = 0.
REQ-025 Reset asserted mid-window discards the partial window; the first window after release starts at count 0.

Configuration
REQ-026 Macro ASK_FSK_RX_AMBIG_EN defined:
- In LOCKED, an AMBIG window on either line suppresses the pair update and pair_valid, and pulses amb_err for one cycle.
REQ-027 Macro ASK_FSK_RX_AMBIG_EN undefined:
- AMBIG is treated by the REQ-016 rule (below HI_MIN = not HIGH) and pair_valid is emitted.
- amb_err is tied to 0.

Verification
REQ-028 Reset, then drive both lines at 30/32 duty -> carrier_ok = 1 after 3 window ends; pair = 2'b11, pair_valid pulsing once every 32 cycles.
REQ-029 Red at 1/32 and green at 30/32 -> pair = 2'b00; red at 30/32 and green at 1/32 -> pair = 2'b01; red at 1/32 and green at 1/32 -> pair = 2'b10.
REQ-030 While LOCKED, hold in_red at 0 for 40 cycles -> carrier_ok drops at the next window end with no pair_valid; restoring PWM gives LOCKED 2 windows after the first valid window.
REQ-031 With ASK_FSK_RX_AMBIG_EN, in_red at 16/32 duty while LOCKED -> amb_err pulse and pair unchanged; without the macro -> pair_valid with pair[0] = 0, amb_err = 0.
REQ-032 Assert rst_n = 0 at window count 17 in LOCKED -> all outputs 0 asynchronously; after release, carrier_ok rises no earlier than 3 full windows later.

Source files
------------

// File: rtl/ask_fsk_rx_if.sv
// Link between the PWM line driver and the ASK/FSK receiver: two raw PWM lines in, decoded symbol out.
// Latency: none, this file only bundles wires.
// Backpressure: none, the receiver outputs are pulses and levels with no ready path.
interface ask_fsk_rx_if;
    logic       in_red;
    logic       in_green;
    logic [1:0] pair;
    logic       pair_valid;
    logic       carrier_ok;
    logic       amb_err;

    // Transmitter / line side: drives the PWM lines and observes the decoded result
    modport master (
        output in_red,
        output in_green,
        input  pair,
        input  pair_valid,
        input  carrier_ok,
        input  amb_err
    );

    // Receiver side
    modport slave (
        input  in_red,
        input  in_green,
        output pair,
        output pair_valid,
        output carrier_ok,
        output amb_err
    );
endinterface

// File: rtl/ask_fsk_rx.sv
// Two-line PWM duty-cycle receiver: measures per-window high counts, decodes a 2-bit symbol, tracks carrier lock.
// Latency: pair/pair_valid update the cycle after a window's last cycle (<= WIN_LEN+3 cycles from a line edge).
// Backpressure: none; pair_valid is a one-cycle pulse. Optional ASK_FSK_RX_AMBIG_EN suppresses ambiguous windows and flags amb_err.
module ask_fsk_rx #(
    parameter int WIN_LEN = 32,
    parameter int LO_MAX  = 3,
    parameter int HI_MIN  = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    ask_fsk_rx_if.slave  bus
);

    localparam int CW = $clog2(WIN_LEN + 1);
    localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    localparam logic [CW-1:0] LO_MAX_C = CW'(LO_MAX);
    localparam logic [CW-1:0] HI_MIN_C = CW'(HI_MIN);

    typedef enum logic [1:0] {
        NO_CARRIER = 2'd0,
        ACQUIRE    = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    logic [1:0]    red_sync;
    logic [1:0]    grn_sync;
    logic          red_s;
    logic          grn_s;
    logic [WW-1:0] win_cnt;
    logic          win_last;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_g;
    logic [CW-1:0] tot_r;
    logic [CW-1:0] tot_g;
    logic          r_none;
    logic          g_none;
    logic          r_hi;
    logic          g_hi;
    logic          r_amb;
    logic          g_amb;
    logic          any_none;
    logic          ambig_blk;
    logic [1:0]    dec_pair;

    state_t        state;
    logic          acq_cnt;
    logic [1:0]    pair_q;
    logic          pair_valid_q;
    logic          carrier_ok_q;
    logic          amb_err_q;

    assign red_s    = red_sync[1];
    assign grn_s    = grn_sync[1];
    assign win_last = (win_cnt == WIN_LAST);

    // Two-flop synchronisers for the asynchronous PWM lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_sync <= 2'b00;
            grn_sync <= 2'b00;
        end else begin
            red_sync <= {red_sync[0], bus.in_red};
            grn_sync <= {grn_sync[0], bus.in_green};
        end
    end

    // Free-running window position; high counters restart at the wrap, seeded with that cycle's sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            cnt_r   <= '0;
            cnt_g   <= '0;
        end else begin
            win_cnt <= win_last ? '0 : win_cnt + 1'b1;
            if (win_cnt == '0) begin
                cnt_r <= CW'(red_s);
                cnt_g <= CW'(grn_s);
            end else begin
                cnt_r <= cnt_r + CW'(red_s);
                cnt_g <= cnt_g + CW'(grn_s);
            end
        end
    end

    // The last cycle's sample is not in the register yet, so fold it in combinationally
    assign tot_r    = cnt_r + CW'(red_s);
    assign tot_g    = cnt_g + CW'(grn_s);
    assign r_none   = (tot_r == '0);
    assign g_none   = (tot_g == '0);
    assign r_hi     = (tot_r >= HI_MIN_C);
    assign g_hi     = (tot_g >= HI_MIN_C);
    assign r_amb    = (tot_r > LO_MAX_C) && !r_hi;
    assign g_amb    = (tot_g > LO_MAX_C) && !g_hi;
    assign any_none = r_none | g_none;

    // Green HIGH repeats the red bit, anything else inverts it
    assign dec_pair = {(g_hi ? r_hi : !r_hi), r_hi};

`ifdef ASK_FSK_RX_AMBIG_EN
    assign ambig_blk = r_amb | g_amb;
`else
    // Ambiguous windows decode like any non-HIGH window
    logic unused_amb;
    assign unused_amb = r_amb | g_amb;
    assign ambig_blk  = 1'b0;
`endif

    // Carrier FSM and registered outputs, evaluated once per window end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= NO_CARRIER;
            acq_cnt      <= 1'b0;
            pair_q       <= 2'b00;
            pair_valid_q <= 1'b0;
            carrier_ok_q <= 1'b0;
            amb_err_q    <= 1'b0;
        end else begin
            pair_valid_q <= 1'b0;
            amb_err_q    <= 1'b0;
            if (win_last) begin
                case (state)
                    NO_CARRIER: begin
                        if (!any_none) begin
                            state   <= ACQUIRE;
                            acq_cnt <= 1'b0;
                        end
                    end
                    ACQUIRE: begin
                        if (any_none) begin
                            state <= NO_CARRIER;
                        end else if (acq_cnt) begin
                            state        <= LOCKED;
                            carrier_ok_q <= 1'b1;
                        end else begin
                            acq_cnt <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (any_none) begin
                            state        <= NO_CARRIER;
                            carrier_ok_q <= 1'b0;
                        end else if (ambig_blk) begin
                            amb_err_q <= 1'b1;
                        end else begin
                            pair_q       <= dec_pair;
                            pair_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                        state        <= NO_CARRIER;
                        carrier_ok_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pair       = pair_q;
    assign bus.pair_valid = pair_valid_q;
    assign bus.carrier_ok = carrier_ok_q;
    assign bus.amb_err    = amb_err_q;

endmodule

// File: tb/tb_ask_fsk_rx.sv
// Directed bench for ask_fsk_rx: lock-up, symbol decode, carrier loss/relock, ambiguous windows, mid-window reset.
// Latency: checks lock after 3 window ends and a 32-cycle pair_valid cadence.
// Backpressure: none; PWM generator free-runs on the falling edge.
module tb_ask_fsk_rx;

    logic clk;
    logic rst_n;
    ask_fsk_rx_if bus ();

    ask_fsk_rx #(.WIN_LEN(32), .LO_MAX(3), .HI_MIN(28)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int pv_cnt   = 0;
    int amb_cnt  = 0;

    int   phase  = 0;
    int   duty_r = 30;
    int   duty_g = 30;
    logic red_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // PWM generator: each line high for the first duty cycles of a 32-cycle frame
    initial begin
        bus.in_red   = 1'b0;
        bus.in_green = 1'b0;
        forever begin
            @(negedge clk);
            phase        = (phase == 31) ? 0 : phase + 1;
            bus.in_red   = red_en && (phase < duty_r);
            bus.in_green = (phase < duty_g);
        end
    end

    // Pulse counters
    always @(negedge clk) begin
        if (bus.pair_valid) pv_cnt++;
        if (bus.amb_err)    amb_cnt++;
    end

    // Change duty at a frame boundary so every window still sees the phase-0 high sample
    task automatic set_duties(input int r, input int g);
        do @(posedge clk); while (phase != 0);
        duty_r = r;
        duty_g = g;
    endtask

    task automatic wait_pv(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.pair_valid) found = 1'b1;
        end
    endtask

    typedef struct {
        int         r;
        int         g;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[3] = '{'{1, 30, 2'b00}, '{30, 1, 2'b01}, '{1, 1, 2'b10}};

    initial begin
        bit  found;
        bit  dropped;
        bit  pv_at_drop;
        int  gap;
        int  relock;
        int  amb_base;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pair",       bus.pair,       0);
        check("rst_pair_valid", bus.pair_valid, 0);
        check("rst_carrier",    bus.carrier_ok, 0);
        check("rst_amb",        bus.amb_err,    0);

        // Lock-up at 30/32 on both lines: carrier at the third window end
        rst_n = 1'b1;
        repeat (93) @(posedge clk);
        #1 check("carrier_before_3win", bus.carrier_ok, 0);
        repeat (6) @(posedge clk);
        #1 check("carrier_after_3win", bus.carrier_ok, 1);

        wait_pv(40, found);
        check("first_pv_seen", found, 1);
        check("pair_both_high", bus.pair, 2'b11);
        @(negedge clk);
        check("pv_one_cycle", bus.pair_valid, 0);
        gap = 1;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.pair_valid && gap < 64);
        check("pv_period", gap, 32);

        // Symbol decode patterns
        foreach (vecs[k]) begin
            set_duties(vecs[k].r, vecs[k].g);
            wait_pv(80, found);
            wait_pv(80, found);
            check($sformatf("pv_seen_%0d", k), found, 1);
            check($sformatf("pair_%0d_%0d", vecs[k].r, vecs[k].g), bus.pair, vecs[k].exp);
        end

        // Carrier loss: red silent over one whole window
        set_duties(30, 30);
        wait_pv(80, found);
        wait_pv(80, found);
        check("pre_loss_pv_seen", found, 1);
        repeat (30) @(posedge clk);
        red_en = 1'b0;
        dropped = 1'b0;
        pv_at_drop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!dropped && !bus.carrier_ok) begin
                dropped = 1'b1;
                pv_at_drop = bus.pair_valid;
            end
        end
        @(posedge clk);
        red_en = 1'b1;
        check("carrier_dropped", dropped, 1);
        check("no_pv_at_drop", pv_at_drop, 0);
        relock = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            relock++;
            if (bus.carrier_ok) found = 1'b1;
        end
        check("relocked", found, 1);
        check("relock_not_early", relock >= 64, 1);

        // Ambiguous red at 16/32 while locked
        wait_pv(80, found);
        check("pre_amb_pair", bus.pair, 2'b11);
        amb_base = amb_cnt;
        set_duties(16, 30);
`ifdef ASK_FSK_RX_AMBIG_EN
        repeat (100) @(negedge clk);
        check("amb_err_pulsed", amb_cnt > amb_base, 1);
        check("amb_pair_held", bus.pair, 2'b11);
`else
        wait_pv(80, found);
        wait_pv(80, found);
        check("amb_pv_seen", found, 1);
        check("amb_pair_decoded", bus.pair, 2'b00);
        check("amb_err_quiet", amb_cnt - amb_base, 0);
`endif

        // Reset at window count 17 while locked
        set_duties(30, 30);
        wait_pv(80, found);
        wait_pv(80, found);
        check("pre_rst_carrier", bus.carrier_ok, 1);
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_pair",       bus.pair,       0);
        check("arst_pair_valid", bus.pair_valid, 0);
        check("arst_carrier",    bus.carrier_ok, 0);
        check("arst_amb",        bus.amb_err,    0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (95) @(posedge clk);
        #1 check("post_rst_carrier_early", bus.carrier_ok, 0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.carrier_ok) found = 1'b1;
        end
        check("post_rst_relock", found, 1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule
